mux_2x1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 2:1 multiplexer datapath. Two requesters present packets (beats with a last flag) over valid/ready handshakes; the block grants one requester at a time, holds the mux select for the whole packet, and forwards beats through a registered output stage. It sits between the two producer blocks and the single downstream consumer, and owns the mux select.

---
 rtl/mux_2x1_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_2x1_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// rtl/mux_2x1_arbiter.sv - round-robin 2:1 packet arbiter with registered output stage
//
// Grants one of two valid/ready requesters per packet, holds the mux select
// until the granted requester's last beat is accepted, and forwards beats
// through a single registered output slot.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in0_valid/in0_data/in0_last/in0_ready  requester 0 beat handshake
//   in1_valid/in1_data/in1_last/in1_ready  requester 1 beat handshake
//   out_valid/out_data/out_last/out_src    registered output beat and its source
//   out_ready                          downstream accepts the output beat
//   sel                                current mux select (granted requester)
//   busy                               a packet is in progress
//   beat_cnt                           saturating beats accepted in current packet
//   pkt_done                           one-cycle pulse after a last beat is accepted
module mux_2x1_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             pkt_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   grant;
  logic   prio;

  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             accept;
  logic             xfer;
  logic             winner;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    if (grant) begin
      g_valid = in1_valid;
      g_last  = in1_last;
      g_data  = in1_data;
    end else begin
      g_valid = in0_valid;
      g_last  = in0_last;
      g_data  = in0_data;
    end
  end

  // The output slot can take a new beat when empty or draining this cycle.
  assign accept    = (state == BUSY) && (!out_valid || out_ready);
  assign xfer      = accept && g_valid;
  assign in0_ready = accept && !grant;
  assign in1_ready = accept && grant;

  // A lone requester wins outright; on a tie prio names the winner.
  assign winner = (in0_valid && in1_valid) ? prio : in1_valid;

  assign sel  = grant;
  assign busy = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      prio      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
      beat_cnt  <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_last  <= g_last;
        out_src   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in0_valid || in1_valid) begin
            grant    <= winner;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (beat_cnt != {CNT_W{1'b1}}) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (g_last) begin
              pkt_done <= 1'b1;
              state    <= IDLE;
              // The loser of this round wins the next tie.
              prio     <= ~grant;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// tb/tb_mux_2x1_arbiter.sv - directed self-checking bench for mux_2x1_arbiter
module tb_mux_2x1_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in0_last, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_last, out_src, out_ready;
  logic [7:0] out_data;
  logic       sel, busy, pkt_done;
  logic [1:0] beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mux_2x1_arbiter #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .sel(sel), .busy(busy), .beat_cnt(beat_cnt), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic l);
    in0_valid = v; in0_data = d; in0_last = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic l);
    in1_valid = v; in1_data = d; in1_last = l;
  endtask

  // Beat fields packed as {last, src, data}; only checked when a beat is expected.
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic s);
    chk({tag, ".out_valid"}, out_valid, v);
    if (v) chk({tag, ".beat"}, {out_last, out_src, out_data}, {l, s, d});
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic s,
                         input logic [1:0] c, input logic done);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".sel"}, sel, s);
    chk({tag, ".beat_cnt"}, beat_cnt, c);
    chk({tag, ".pkt_done"}, pkt_done, done);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".outs"}, {out_valid, out_last, out_src, out_data}, 11'd0);
    chk_ctl(tag, 1'b0, 1'b0, 2'd0, 1'b0);
    chk({tag, ".ready"}, {in0_ready, in1_ready}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    set0(1'b0, 8'h00, 1'b0);
    set1(1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // Single requester, three beats.
    set0(1'b1, 8'hA1, 1'b0);
    chk("idle.in0_ready", in0_ready, 1'b0);
    tick();
    chk_ctl("s.grant", 1'b1, 1'b0, 2'd0, 1'b0);
    chk("s.grant.ready", {in0_ready, in1_ready}, 2'b10);
    chk_out("s.grant", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_out("s.b1", 1'b1, 8'hA1, 1'b0, 1'b0);
    chk("s.b1.cnt", beat_cnt, 2'd1);
    set0(1'b1, 8'hA2, 1'b0);
    tick();
    chk_out("s.b2", 1'b1, 8'hA2, 1'b0, 1'b0);
    chk("s.b2.cnt", beat_cnt, 2'd2);
    set0(1'b1, 8'hA3, 1'b1);
    tick();
    chk_out("s.b3", 1'b1, 8'hA3, 1'b1, 1'b0);
    chk_ctl("s.b3", 1'b0, 1'b0, 2'd3, 1'b1);
    set0(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("s.after", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("s.after.done", pkt_done, 1'b0);

    // Reset in the middle of an in1 packet (prio is 1 here, but in1 is alone).
    set1(1'b1, 8'h51, 1'b0);
    tick();
    chk("r.grant.sel", sel, 1'b1);
    tick();
    chk_out("r.b1", 1'b1, 8'h51, 1'b0, 1'b1);
    set1(1'b1, 8'h52, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("r.async");
    tick();
    chk_zero("r.held");
    rst_n = 1'b1;

    // Contention: both request continuously; prio restarts at 0 after reset.
    set0(1'b1, 8'h01, 1'b0);
    set1(1'b1, 8'h11, 1'b0);
    tick();
    chk_ctl("c.g0", 1'b1, 1'b0, 2'd0, 1'b0);
    chk("c.g0.ready", {in0_ready, in1_ready}, 2'b10);
    tick();
    chk_out("c.01", 1'b1, 8'h01, 1'b0, 1'b0);
    set0(1'b1, 8'h02, 1'b1);
    tick();
    chk_out("c.02", 1'b1, 8'h02, 1'b1, 1'b0);
    chk_ctl("c.02", 1'b0, 1'b0, 2'd2, 1'b1);
    set0(1'b1, 8'h03, 1'b0);
    tick();
    chk_out("c.bub1", 1'b0, 8'h00, 1'b0, 1'b0);
    chk_ctl("c.g1", 1'b1, 1'b1, 2'd0, 1'b0);
    chk("c.g1.ready", {in0_ready, in1_ready}, 2'b01);
    tick();
    chk_out("c.11", 1'b1, 8'h11, 1'b0, 1'b1);
    set1(1'b1, 8'h12, 1'b1);
    tick();
    chk_out("c.12", 1'b1, 8'h12, 1'b1, 1'b1);
    chk("c.12.done", pkt_done, 1'b1);
    chk("c.12.sel", sel, 1'b1);
    set1(1'b1, 8'h13, 1'b0);
    tick();
    chk_out("c.bub2", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("c.g0b.sel", sel, 1'b0);
    tick();
    chk_out("c.03", 1'b1, 8'h03, 1'b0, 1'b0);
    set0(1'b1, 8'h04, 1'b1);
    tick();
    chk_out("c.04", 1'b1, 8'h04, 1'b1, 1'b0);
    set0(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("c.bub3", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("c.g1b.sel", sel, 1'b1);
    tick();
    chk_out("c.13", 1'b1, 8'h13, 1'b0, 1'b1);
    set1(1'b1, 8'h14, 1'b1);
    tick();
    chk_out("c.14", 1'b1, 8'h14, 1'b1, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("c.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Backpressure: out_ready low for 3 cycles mid-packet.
    set0(1'b1, 8'hB1, 1'b0);
    tick();
    chk("bp.grant.busy", busy, 1'b1);
    tick();
    chk_out("bp.b1", 1'b1, 8'hB1, 1'b0, 1'b0);
    set0(1'b1, 8'hB2, 1'b0);
    tick();
    chk_out("bp.b2", 1'b1, 8'hB2, 1'b0, 1'b0);
    set0(1'b1, 8'hB3, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp.stall.ready", in0_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 8'hB2, 1'b0, 1'b0);
      chk("bp.hold.ready", in0_ready, 1'b0);
      chk("bp.hold.cnt", beat_cnt, 2'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.resume.ready", in0_ready, 1'b1);
    tick();
    chk_out("bp.b3", 1'b1, 8'hB3, 1'b0, 1'b0);
    set0(1'b1, 8'hB4, 1'b0);
    tick();
    chk_out("bp.b4", 1'b1, 8'hB4, 1'b0, 1'b0);
    set0(1'b1, 8'hB5, 1'b1);
    tick();
    chk_out("bp.b5", 1'b1, 8'hB5, 1'b1, 1'b0);
    chk_ctl("bp.b5", 1'b0, 1'b0, 2'd3, 1'b1);
    set0(1'b0, 8'h00, 1'b0);
    tick();
    chk_out("bp.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Grant hold: in1 granted, stalls 4 cycles while in0 waits.
    set1(1'b1, 8'hC1, 1'b0);
    tick();
    chk("gh.grant.sel", sel, 1'b1);
    set0(1'b1, 8'hD1, 1'b1);
    tick();
    chk_out("gh.c1", 1'b1, 8'hC1, 1'b0, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ctl("gh.stall", 1'b1, 1'b1, 2'd1, 1'b0);
      chk("gh.stall.ready", {in0_ready, in1_ready}, 2'b01);
      chk_out("gh.stall", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    set1(1'b1, 8'hC2, 1'b0);
    tick();
    chk_out("gh.c2", 1'b1, 8'hC2, 1'b0, 1'b1);
    set1(1'b1, 8'hC3, 1'b1);
    tick();
    chk_out("gh.c3", 1'b1, 8'hC3, 1'b1, 1'b1);
    chk("gh.c3.done", pkt_done, 1'b1);
    set1(1'b0, 8'h00, 1'b0);
    tick();
    chk_ctl("gh.g0", 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    chk_out("gh.d1", 1'b1, 8'hD1, 1'b1, 1'b0);
    chk("gh.d1.done", pkt_done, 1'b1);
    set0(1'b0, 8'h00, 1'b0);
    tick();

    // Saturation: 6-beat packet with a 2-bit counter.
    set0(1'b1, 8'hE0, 1'b0);
    tick();
    chk("sat.grant.cnt", beat_cnt, 2'd0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] expc;
      expc = (i >= 2) ? 2'd3 : 2'(i + 1);
      set0(1'b1, 8'hE0 + 8'(i), (i == 5));
      tick();
      chk("sat.cnt", beat_cnt, expc);
      chk_out("sat.beat", 1'b1, 8'hE0 + 8'(i), (i == 5), 1'b0);
    end
    set0(1'b0, 8'h00, 1'b0);
    tick();
    chk("sat.end.busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
